// File: rtl/rx_sync_ctrl_if.sv
// rx_sync_ctrl_if: symbol-side and decoder-side signals of rx_sync_ctrl.
//   master : symbol source + decoder model (drives sym/valid/dec_byte/err_clr)
//   slave  : rx_sync_ctrl itself
interface rx_sync_ctrl_if;
    logic [9:0]  sym_i;
    logic        sym_valid_i;
    logic [9:0]  dec_data_o;
    logic        dec_enable_o;
    logic [7:0]  dec_byte_i;
    logic [7:0]  data_o;
    logic        data_valid_o;
    logic        comma_o;
    logic        sync_o;
    logic        code_err_o;
    logic        rd_o;
    logic        err_clr_i;
    logic [15:0] err_cnt_o;

    modport master (
        output sym_i, sym_valid_i, dec_byte_i, err_clr_i,
        input  dec_data_o, dec_enable_o, data_o, data_valid_o, comma_o,
               sync_o, code_err_o, rd_o, err_cnt_o
    );

    modport slave (
        input  sym_i, sym_valid_i, dec_byte_i, err_clr_i,
        output dec_data_o, dec_enable_o, data_o, data_valid_o, comma_o,
               sync_o, code_err_o, rd_o, err_cnt_o
    );
endinterface

// File: rtl/rx_sync_ctrl.sv
// rx_sync_ctrl: receive-side sequencer in front of a 10b->8b decoder.
//   Classifies raw symbols, tracks running disparity, acquires word sync on
//   K28.5 commas and drops it on repeated code errors. Symbols go to the
//   decoder through one register stage; the decoded byte is captured one
//   cycle later and flagged valid only for symbols accepted while in sync.
// Ports:
//   clk_i, rst_i : clock (rising), async active-high reset
//   bus (slave)  : sym_i/sym_valid_i in, dec_data_o/dec_enable_o to decoder,
//                  dec_byte_i from decoder, data_o/data_valid_o/comma_o out,
//                  sync_o, code_err_o, rd_o, err_clr_i, err_cnt_o
// Build option: RX_ERR_CNT_EN builds the saturating code-error counter;
//   without it err_cnt_o is tied to 0 and err_clr_i is ignored.
module rx_sync_ctrl #(
    parameter int COMMA_CNT = 3,
    parameter int BAD_LIMIT = 3,
    parameter int GOOD_RUN  = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    rx_sync_ctrl_if.slave bus
);
    localparam logic [1:0] LOS  = 2'd0;
    localparam logic [1:0] ACQ  = 2'd1;
    localparam logic [1:0] SYNC = 2'd2;

    logic [1:0] state, state_n;
    logic [3:0] ccnt, ccnt_n, bad, bad_n, good, good_n;
    logic       rd;
    logic [3:0] ones;
    logic       acc, invalid, comma;
    logic       comma_q, emit_q;

    assign acc   = bus.sym_valid_i;
    assign ones  = 4'($countones(bus.sym_i));
    assign comma = (bus.sym_i[9:3] == 7'b0011111) || (bus.sym_i[9:3] == 7'b1100000);
    // Bad weight, or a weight that pushes disparity further the same way.
    assign invalid = (ones < 4'd4) || (ones > 4'd6) ||
                     (ones == 4'd6 && rd) || (ones == 4'd4 && !rd);

    always_comb begin
        state_n = state;
        ccnt_n  = ccnt;
        bad_n   = bad;
        good_n  = good;
        if (acc) begin
            case (state)
                LOS: if (!invalid && comma) begin
                    state_n = (COMMA_CNT == 1) ? SYNC : ACQ;
                    ccnt_n  = 4'd1;
                end
                ACQ: if (invalid) begin
                    state_n = LOS;
                end else if (comma) begin
                    ccnt_n = ccnt + 4'd1;
                    if (ccnt_n == 4'(COMMA_CNT)) state_n = SYNC;
                end
                SYNC: if (invalid) begin
                    bad_n  = bad + 4'd1;
                    good_n = 4'd0;
                    if (bad_n == 4'(BAD_LIMIT)) state_n = LOS;
                end else begin
                    good_n = good + 4'd1;
                    if (good_n == 4'(GOOD_RUN)) begin
                        good_n = 4'd0;
                        bad_n  = (bad != 4'd0) ? bad - 4'd1 : 4'd0;
                    end
                end
                default: state_n = LOS;
            endcase
        end
        // Every entry into LOS or SYNC starts the counters from scratch.
        if (state_n != state && state_n != ACQ) begin
            ccnt_n = 4'd0;
            bad_n  = 4'd0;
            good_n = 4'd0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= LOS;
            ccnt  <= 4'd0;
            bad   <= 4'd0;
            good  <= 4'd0;
            rd    <= 1'b0;
        end else begin
            state <= state_n;
            ccnt  <= ccnt_n;
            bad   <= bad_n;
            good  <= good_n;
            if (acc) begin
                if (ones >= 4'd6)      rd <= 1'b1;
                else if (ones <= 4'd4) rd <= 1'b0;
            end
        end
    end

    // Stage 1: feed the decoder, remember comma/emit alongside the symbol.
    // emit_q uses the present state, so the acquiring comma is not emitted
    // while the symbol that drops sync still is.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bus.dec_data_o   <= 10'd0;
            bus.dec_enable_o <= 1'b0;
            bus.code_err_o   <= 1'b0;
            comma_q          <= 1'b0;
            emit_q           <= 1'b0;
        end else begin
            if (acc) bus.dec_data_o <= bus.sym_i;
            bus.dec_enable_o <= acc;
            bus.code_err_o   <= acc && invalid;
            comma_q          <= acc && comma;
            emit_q           <= acc && (state == SYNC);
        end
    end

    // Stage 2: capture the decoder's combinational result.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bus.data_o       <= 8'd0;
            bus.comma_o      <= 1'b0;
            bus.data_valid_o <= 1'b0;
        end else begin
            if (bus.dec_enable_o) begin
                bus.data_o  <= bus.dec_byte_i;
                bus.comma_o <= comma_q;
            end
            bus.data_valid_o <= emit_q;
        end
    end

    assign bus.sync_o = (state == SYNC);
    assign bus.rd_o   = rd;

`ifdef RX_ERR_CNT_EN
    logic [15:0] err_cnt;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                                    err_cnt <= 16'd0;
        else if (bus.err_clr_i)                       err_cnt <= 16'd0;
        else if (acc && invalid && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
    assign bus.err_cnt_o = err_cnt;
`else
    logic unused_err_clr;
    assign unused_err_clr = bus.err_clr_i;
    assign bus.err_cnt_o  = 16'd0;
`endif
endmodule
